// File: rtl/int_to_float_sequencer_pkg.sv
// Shared types and constants for the integer-to-binary32 converter.
package int_to_float_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        NORMALIZE = 2'd1,
        ROUND     = 2'd2,
        HOLD      = 2'd3
    } seqState_t;

    localparam int unsigned INT_W    = 32;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned EXP_BIAS = 127;
    // Exponent of a value whose leading one sits at bit INT_W-1.
    localparam int unsigned EXP_BASE = EXP_BIAS + INT_W - 1;

endpackage

// File: rtl/int_to_float_sequencer_lzd.sv
// Leading-zero count of a 32-bit word; all-zero input reports 32.
module leadingZerosDetector (
    input  logic [31:0] value,
    output logic [5:0]  zeros
);

    // Scan upward so the most significant set bit wins.
    always_comb begin
        zeros = 6'd32;
        for (int unsigned i = 0; i < 32; i++) begin
            if (value[i]) begin
                zeros = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/int_to_float_sequencer.sv
// Multi-cycle integer to binary32 converter with round-to-nearest-even.
module int_to_float_sequencer
    import int_to_float_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [INT_W-1:0]  inData,
    input  logic              inSigned,
    output logic              outValid,
    input  logic              outReady,
    output logic [31:0]       outData,
    output logic              outInexact
);

    seqState_t          state;
    seqState_t          stateNext;
    logic               accept;

    logic               sign;
    logic [INT_W-1:0]   mag;
    logic [INT_W-1:0]   norm;
    logic [8:0]         exp;
    logic               isZero;
    logic [5:0]         zeros;

    logic [MANT_W-1:0]  mant;
    logic               guard;
    logic               sticky;
    logic               up;
    logic [MANT_W:0]    mantSum;
    logic [MANT_W-1:0]  mantRound;
    logic [8:0]         expRound;
    logic [1:0]         unusedBits;

    leadingZerosDetector u_lzd (
        .value (mag),
        .zeros (zeros)
    );

    // Handshake: ready in IDLE, or in HOLD when the consumer retires the result.
    always_comb begin
        inReady = 1'b0;
        if (state == IDLE) begin
            inReady = 1'b1;
        end else if (state == HOLD) begin
            inReady = outReady;
        end
    end

    assign accept   = inValid & inReady;
    assign outValid = (state == HOLD);

    // Next-state selection.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:      if (inValid) stateNext = NORMALIZE;
            NORMALIZE: stateNext = ROUND;
            ROUND:     stateNext = HOLD;
            HOLD: begin
                if (outReady) begin
                    stateNext = inValid ? NORMALIZE : IDLE;
                end
            end
            default:   stateNext = IDLE;
        endcase
    end

    // Round-to-nearest-even on the normalized magnitude.
    always_comb begin
        mant      = norm[30:8];
        guard     = norm[7];
        sticky    = |norm[6:0];
        up        = guard & (sticky | mant[0]);
        mantSum   = {1'b0, mant} + (MANT_W + 1)'(up);
        mantRound = mantSum[MANT_W] ? '0 : mantSum[MANT_W-1:0];
        expRound  = exp + 9'(mantSum[MANT_W]);
    end

    // exp never exceeds 159, and norm[31] is the implicit leading one.
    assign unusedBits = {expRound[8], norm[31]};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Datapath registers advanced by the current phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign       <= 1'b0;
            mag        <= '0;
            norm       <= '0;
            exp        <= '0;
            isZero     <= 1'b0;
            outData    <= '0;
            outInexact <= 1'b0;
        end else begin
            if (accept) begin
                sign <= inSigned & inData[INT_W-1];
                mag  <= (inSigned & inData[INT_W-1]) ? (~inData + 32'd1) : inData;
            end
            if (state == NORMALIZE) begin
                norm   <= mag << zeros;
                exp    <= 9'(EXP_BASE) - {3'b000, zeros};
                isZero <= (zeros == 6'd32);
            end
            if (state == ROUND) begin
                outData    <= isZero ? '0 : {sign, expRound[7:0], mantRound};
                outInexact <= isZero ? 1'b0 : (guard | sticky);
            end
        end
    end

endmodule

// File: tb/tb_int_to_float_sequencer.sv
// Directed bench for int_to_float_sequencer.
module tb_int_to_float_sequencer;

    logic        clk;
    logic        reset_n;
    logic        inValid;
    logic        inReady;
    logic [31:0] inData;
    logic        inSigned;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic        outInexact;

    int tests;
    int failures;

    int_to_float_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .inValid    (inValid),
        .inReady    (inReady),
        .inData     (inData),
        .inSigned   (inSigned),
        .outValid   (outValid),
        .outReady   (outReady),
        .outData    (outData),
        .outInexact (outInexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full conversion from IDLE with outReady high; checks latency too.
    task automatic convert(input string tag, input logic [31:0] d, input logic s,
                           input logic [31:0] expData, input logic expInexact);
        inData   = d;
        inSigned = s;
        inValid  = 1'b1;
        outReady = 1'b1;
        check({tag, "_ready"}, {31'd0, inReady}, 32'd1);
        step();                                  // E0: accept
        inValid = 1'b0;
        check({tag, "_v_e0"}, {31'd0, outValid}, 32'd0);
        check({tag, "_rdy_e0"}, {31'd0, inReady}, 32'd0);
        step();                                  // E1
        check({tag, "_v_e1"}, {31'd0, outValid}, 32'd0);
        step();                                  // E2: result
        check({tag, "_v_e2"}, {31'd0, outValid}, 32'd1);
        check({tag, "_data"}, outData, expData);
        check({tag, "_inex"}, {31'd0, outInexact}, {31'd0, expInexact});
        step();                                  // retired, back to IDLE
        check({tag, "_v_done"}, {31'd0, outValid}, 32'd0);
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        reset_n  = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inSigned = 1'b0;
        outReady = 1'b0;

        #12;
        check("rst_valid", {31'd0, outValid}, 32'd0);
        check("rst_data", outData, 32'd0);
        check("rst_inex", {31'd0, outInexact}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("rst_ready", {31'd0, inReady}, 32'd1);

        convert("s_one",      32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0);
        convert("s_minus1",   32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0);
        convert("u_max",      32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1);
        convert("zero",       32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
        convert("s_min",      32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0);
        convert("u_2p31",     32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0);
        convert("tie_down",   32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1);
        convert("tie_up",     32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1);
        convert("exact_lsb",  32'h0100_0002, 1'b0, 32'h4B80_0001, 1'b0);
        convert("s_m100",     32'hFFFF_FF9C, 1'b1, 32'hC2C8_0000, 1'b0);
        convert("u_24bit",    32'h00FF_FFFF, 1'b0, 32'h4B7F_FFFF, 1'b0);
        convert("s_maxpos",   32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 1'b1);

        // Backpressure: result 5.0 held while the consumer stalls.
        inData   = 32'd5;
        inSigned = 1'b0;
        inValid  = 1'b1;
        outReady = 1'b0;
        step();
        inValid = 1'b0;
        step();
        step();
        check("bp_valid", {31'd0, outValid}, 32'd1);
        check("bp_data", outData, 32'h40A0_0000);
        inData  = 32'd7;                         // offered while not ready: ignored
        inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", {31'd0, outValid}, 32'd1);
            check("bp_hold_data", outData, 32'h40A0_0000);
            check("bp_hold_rdy", {31'd0, inReady}, 32'd0);
        end
        inData   = 32'd3;
        outReady = 1'b1;
        #1;
        check("bp_comb_rdy", {31'd0, inReady}, 32'd1);
        step();                                  // retire + accept on same edge
        inValid = 1'b0;
        check("bp_retired", {31'd0, outValid}, 32'd0);
        step();
        check("bp_not_yet", {31'd0, outValid}, 32'd0);
        step();
        check("bp_next_valid", {31'd0, outValid}, 32'd1);
        check("bp_next_data", outData, 32'h4040_0000);
        check("bp_next_inex", {31'd0, outInexact}, 32'd0);
        step();
        check("bp_idle", {31'd0, outValid}, 32'd0);

        // Reset while in NORMALIZE: old result register must clear at once.
        inData   = 32'd9;
        inSigned = 1'b0;
        inValid  = 1'b1;
        step();
        inValid = 1'b0;
        check("ar_pre_data", outData, 32'h4040_0000);
        reset_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, outValid}, 32'd0);
        check("ar_data", outData, 32'd0);
        check("ar_inex", {31'd0, outInexact}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("ar_ready", {31'd0, inReady}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("ar_no_stale", {31'd0, outValid}, 32'd0);
            check("ar_data_zero", outData, 32'd0);
        end

        convert("post_rst", 32'h0000_0002, 1'b0, 32'h4000_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/int_to_float_sequencer.md
# int_to_float_sequencer

Multi-cycle integer-to-IEEE-754 single-precision converter controller. It accepts a 32-bit signed or unsigned integer over a valid/ready handshake and sequences the shared `leadingZerosDetector` through normalize and round phases. It returns a round-to-nearest-even float over a second valid/ready handshake. It sits between the integer producer and the float consumer as the conversion engine.

## Interface
- No parameters; all widths are fixed at 32-bit integer in and binary32 out.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `inValid`  in  1  producer offers `inData`/`inSigned`.
- `inReady`  out  1  block accepts this cycle; combinational from state and `outReady`.
- `inData`  in  32  integer operand.
- `inSigned`  in  1  1 = two's-complement operand, 0 = unsigned.
- `outValid`  out  1  `outData`/`outInexact` hold a result.
- `outReady`  in  1  consumer takes the result.
- `outData`  out  32  binary32 result.
- `outInexact`  out  1  result was rounded (guard or sticky set).

## Operation
- A transfer occurs on an edge where valid and ready are both high, on either port.
- FSM states are IDLE, NORMALIZE, ROUND and HOLD.
- **IDLE:**
  - `inReady`=1.
  - On accept, register `sign` = `inSigned & inData[31]`.
  - Register `mag` = `sign ? -inData : inData`, 32-bit wrap. −2^31 yields 0x80000000 treated as unsigned.
  - Go to NORMALIZE.
- **NORMALIZE:**
  - `leadingZerosDetector` is driven from `mag`, giving `zeros` 0..32.
  - Register `norm` = `mag << zeros`; bit 31 is set unless `mag`=0.
  - Register `exp` (9 bits) = 158 − `zeros`.
  - Register `isZero` = (`zeros`==32).
  - Go to ROUND.
- **ROUND:**
  - mant = `norm[30:8]`, guard = `norm[7]`, sticky = `|norm[6:0]`.
  - up = guard & (sticky | mant[0]).
  - {carry, mant'} = mant + up; on carry, mant' = 0 and exp = exp + 1.
  - `outData` = isZero ? 0x00000000 : {sign, exp[7:0], mant'}.
  - `outInexact` = guard | sticky (0 for zero).
  - Set `outValid`=1 and go to HOLD.
- **HOLD:**
  - `outValid`=1 and `outData` is stable.
  - `inReady` = `outReady`.
  - `outReady` & `inValid`: the result is retired and the new operand is accepted on the same edge; go to NORMALIZE.
  - `outReady` & !`inValid`: clear `outValid` and go to IDLE.
  - !`outReady`: stay in HOLD.
- Exponent never overflows; the maximum is 158+1 = 159. No NaN, Inf or denormal outputs are produced.
- Zero input never produces −0.

## Timing
- Reset values:
  - state IDLE.
  - `outValid`=0, `outData`=0, `outInexact`=0.
  - `inReady`=1 once `reset_n` deasserts.
  - Internal registers are cleared to 0.
- Latency: with accept on edge E0, `outValid` rises at E2, i.e. it is visible in the cycle after E2.
- Throughput with `outReady` held high and continuous `inValid` is one result per 3 cycles.
- `inReady` depends combinationally on `outReady` in HOLD only. There is no combinational path from `inValid` to any output.
- `outData`/`outInexact` change only on the ROUND→HOLD edge.
- Reset asserted mid-operation (any state) aborts the transaction immediately. The operand is dropped and all outputs return to reset values asynchronously.
- `inValid` while not ready is ignored, and the operand is not captured.

## Structure
- Package `int_to_float_pkg` holds:
  - state enum `seqState_t` {IDLE, NORMALIZE, ROUND, HOLD}.
  - constants `EXP_BIAS`=127, `EXP_BASE`=158, `MANT_W`=23, `INT_W`=32.
- One sub-module instance: the existing `leadingZerosDetector` (32-bit in, 6-bit `zeros` out), driven from the registered `mag`.
- The rounding adder and exponent increment are inline in the ROUND state logic.

## Test plan
- Signed 1, `outReady`=1 → `outData`=0x3F800000, `outInexact`=0, `outValid` at E2.
- Signed 0xFFFFFFFF → 0xBF800000. Unsigned 0xFFFFFFFF → 0x4F800000 with `outInexact`=1 (mantissa carry increments the exponent).
- Zero → 0x00000000 with `outInexact`=0. Signed 0x80000000 → 0xCF000000. Unsigned 0x80000000 → 0x4F000000.
- Tie cases:
  - 0x01000001 → 0x4B800000 (tie, rounds down to even), inexact=1.
  - 0x01000003 → 0x4B800002 (tie, rounds up to even), inexact=1.
  - 0x01000002 → 0x4B800001, inexact=0.
- Backpressure:
  - Hold `outReady`=0 for 5 cycles in HOLD → `outData` stable, `inReady`=0.
  - Then raise `outReady` with `inValid`=1 → retire and accept on the same edge; the next result appears 2 edges later.
- Pull `reset_n` low while in NORMALIZE → `outValid`=0 and `outData`=0 immediately. After release, `inReady`=1 and no stale result emerges.
